// File: rtl/kernel_kcore_fifo_param.sv
// Single-clock ap_fifo channel, shift-register or RAM+prefetch storage; write-to-empty_n latency 1 (shiftreg) or 2 (ram).
// Back-pressure via registered full_n and almost flags; requests against a low flag are dropped with no side effect.
module kernel_kcore_fifo_param #(
    parameter string MEM_STYLE  = "shiftreg",
    parameter int    DATA_WIDTH = 64,
    parameter int    DEPTH      = 4,
    parameter int    ADDR_WIDTH = 2,
    parameter int    AF_MARGIN  = 1,
    parameter int    AE_MARGIN  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  if_empty_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_full_n,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic [ADDR_WIDTH:0]   if_num_data_valid,
    output logic                  if_almost_full_n,
    output logic                  if_almost_empty_n
);
    localparam int CW = ADDR_WIDTH + 1;
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t DEPTH_C = cnt_t'(DEPTH);
    localparam cnt_t AF_TH   = cnt_t'(DEPTH - AF_MARGIN);
    localparam cnt_t AE_TH   = cnt_t'(AE_MARGIN);
    localparam cnt_t CNT_ONE = cnt_t'(1);

    logic wr;
    logic rd;
    cnt_t count;
    cnt_t count_nxt;
    logic full_n_q;
    logic af_n_q;
    logic ae_n_q;

    assign wr = if_write & if_write_ce & full_n_q;
    assign rd = if_read & if_read_ce & if_empty_n;

    always_comb begin
        count_nxt = count;
        case ({wr, rd})
            2'b10:   count_nxt = count + CNT_ONE;
            2'b01:   count_nxt = count - CNT_ONE;
            default: count_nxt = count;
        endcase
    end

    // Flags are registered from next-count so they move in the same cycle as count.
    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= '0;
            full_n_q <= 1'b1;
            af_n_q   <= 1'b1;
            ae_n_q   <= 1'b0;
        end else begin
            count    <= count_nxt;
            full_n_q <= (count_nxt != DEPTH_C);
            af_n_q   <= !(count_nxt >= AF_TH);
            ae_n_q   <= !(count_nxt <= AE_TH);
        end
    end

    assign if_full_n         = full_n_q;
    assign if_num_data_valid = count;
    assign if_almost_full_n  = af_n_q;
    assign if_almost_empty_n = ae_n_q;

    if (MEM_STYLE == "shiftreg") begin : g_srl
        logic [DATA_WIDTH-1:0] srl [DEPTH];
        logic [ADDR_WIDTH-1:0] ptr;
        logic                  empty_n_q;

        always_ff @(posedge clk) begin
            if (!reset && wr) begin
                srl[0] <= if_din;
                for (int i = 1; i < DEPTH; i++) begin
                    srl[i] <= srl[i-1];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                empty_n_q <= 1'b0;
            end else begin
                empty_n_q <= (count_nxt != '0);
            end
        end

        // Clamp at zero so an empty FIFO never indexes past the array.
        assign ptr        = (count == '0) ? '0 : ADDR_WIDTH'(count - CNT_ONE);
        assign if_dout    = srl[ptr];
        assign if_empty_n = empty_n_q;
    end else if (MEM_STYLE == "ram") begin : g_ram
        typedef logic [ADDR_WIDTH-1:0] ptr_t;
        localparam ptr_t PTR_LAST = ptr_t'(DEPTH - 2);
        localparam ptr_t PTR_ONE  = ptr_t'(1);

        logic [DATA_WIDTH-1:0] mem [DEPTH-1];
        logic [DATA_WIDTH-1:0] dout_q;
        ptr_t                  wptr;
        ptr_t                  rptr;
        cnt_t                  mem_cnt;
        logic                  dout_valid;
        logic                  fetch;

        // Refill the output register whenever it is empty or being drained this cycle.
        assign fetch = (mem_cnt != '0) && (!dout_valid || rd);

        always_ff @(posedge clk) begin
            if (!reset && wr) begin
                mem[wptr] <= if_din;
            end
            if (!reset && fetch) begin
                dout_q <= mem[rptr];
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                wptr       <= '0;
                rptr       <= '0;
                mem_cnt    <= '0;
                dout_valid <= 1'b0;
            end else begin
                if (wr) begin
                    wptr <= (wptr == PTR_LAST) ? '0 : wptr + PTR_ONE;
                end
                if (fetch) begin
                    rptr <= (rptr == PTR_LAST) ? '0 : rptr + PTR_ONE;
                end
                case ({wr, fetch})
                    2'b10:   mem_cnt <= mem_cnt + CNT_ONE;
                    2'b01:   mem_cnt <= mem_cnt - CNT_ONE;
                    default: mem_cnt <= mem_cnt;
                endcase
                dout_valid <= fetch | (dout_valid & !rd);
            end
        end

        assign if_dout    = dout_q;
        assign if_empty_n = dout_valid;
    end else begin : g_bad_style
        $error("kernel_kcore_fifo_param: MEM_STYLE must be \"shiftreg\" or \"ram\"");
    end

endmodule

// File: tb/tb_kernel_kcore_fifo_param.sv
// Bench for kernel_kcore_fifo_param: shiftreg DEPTH=4 (index 0) and ram DEPTH=5 (index 1) instances.
module tb_kernel_kcore_fifo_param;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        write [2];
    logic        write_ce [2];
    logic        read [2];
    logic        read_ce [2];
    logic [15:0] din [2];
    logic [15:0] dout [2];
    logic        empty_n [2];
    logic        full_n [2];
    logic        af_n [2];
    logic        ae_n [2];
    logic [2:0]  cnt0;
    logic [3:0]  cnt1;

    kernel_kcore_fifo_param #(
        .MEM_STYLE("shiftreg"), .DATA_WIDTH(16), .DEPTH(4), .ADDR_WIDTH(2),
        .AF_MARGIN(1), .AE_MARGIN(1)
    ) u_srl (
        .clk(clk), .reset(reset),
        .if_empty_n(empty_n[0]), .if_read_ce(read_ce[0]), .if_read(read[0]), .if_dout(dout[0]),
        .if_full_n(full_n[0]), .if_write_ce(write_ce[0]), .if_write(write[0]), .if_din(din[0]),
        .if_num_data_valid(cnt0), .if_almost_full_n(af_n[0]), .if_almost_empty_n(ae_n[0])
    );

    kernel_kcore_fifo_param #(
        .MEM_STYLE("ram"), .DATA_WIDTH(16), .DEPTH(5), .ADDR_WIDTH(3),
        .AF_MARGIN(1), .AE_MARGIN(1)
    ) u_ram (
        .clk(clk), .reset(reset),
        .if_empty_n(empty_n[1]), .if_read_ce(read_ce[1]), .if_read(read[1]), .if_dout(dout[1]),
        .if_full_n(full_n[1]), .if_write_ce(write_ce[1]), .if_write(write[1]), .if_din(din[1]),
        .if_num_data_valid(cnt1), .if_almost_full_n(af_n[1]), .if_almost_empty_n(ae_n[1])
    );

    int checks = 0;
    int errors = 0;
    int mc [2];
    logic [15:0] sb0 [$];
    logic [15:0] sb1 [$];
    bit last_wr;

    function automatic int depth(int m);
        return (m == 0) ? 4 : 5;
    endfunction

    function automatic int cnt(int m);
        return (m == 0) ? int'(cnt0) : int'(cnt1);
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(string name);
        checks++;
        errors++;
        $display("FAIL %s t=%0t", name, $time);
    endtask

    // One clock of stimulus on instance m; model and scoreboard checks happen at the falling edge.
    task automatic cyc(int m, bit w, bit wce, bit r, bit rce, logic [15:0] d, bit rst = 1'b0);
        bit wr_acc;
        bit rd_acc;
        for (int k = 0; k < 2; k++) begin
            write[k] = 1'b0; write_ce[k] = 1'b0; read[k] = 1'b0; read_ce[k] = 1'b0;
        end
        write[m] = w; write_ce[m] = wce; read[m] = r; read_ce[m] = rce; din[m] = d;
        reset = rst;
        @(negedge clk);
        chk("count", cnt(m), mc[m]);
        chk("full_n", int'(full_n[m]), int'(mc[m] != depth(m)));
        chk("almost_full_n", int'(af_n[m]), int'(!(mc[m] >= depth(m) - 1)));
        chk("almost_empty_n", int'(ae_n[m]), int'(!(mc[m] <= 1)));
        if (m == 0) chk("srl_empty_n", int'(empty_n[0]), int'(mc[0] != 0));
        else if (empty_n[1] && mc[1] == 0) fail("ram_empty_n_with_zero_count");
        wr_acc = w & wce & full_n[m];
        rd_acc = r & rce & empty_n[m];
        if (empty_n[m]) begin
            if (m == 0) begin
                if (sb0.size() == 0) fail("srl_unexpected_word");
                else chk("srl_dout_head", int'(dout[0]), int'(sb0[0]));
            end else begin
                if (sb1.size() == 0) fail("ram_unexpected_word");
                else chk("ram_dout_head", int'(dout[1]), int'(sb1[0]));
            end
        end
        if (rst) begin
            mc[0] = 0; mc[1] = 0;
            sb0.delete(); sb1.delete();
        end else begin
            if (rd_acc) begin
                if (m == 0 && sb0.size() > 0) void'(sb0.pop_front());
                if (m == 1 && sb1.size() > 0) void'(sb1.pop_front());
            end
            if (wr_acc) begin
                if (m == 0) sb0.push_back(d);
                else sb1.push_back(d);
            end
            mc[m] = mc[m] + int'(wr_acc) - int'(rd_acc);
        end
        last_wr = wr_acc;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic fill(int m, int n, logic [15:0] base);
        for (int i = 0; i < n; i++) cyc(m, 1, 1, 0, 0, base + 16'(i));
    endtask

    task automatic drain(int m);
        for (int i = 0; i < 40 && mc[m] != 0; i++) cyc(m, 0, 0, 1, 1, 16'h0);
        if (mc[m] != 0) fail("drain_timeout");
        cyc(m, 0, 0, 0, 0, 16'h0);
        cyc(m, 0, 0, 0, 0, 16'h0);
        chk("empty_n_after_drain", int'(empty_n[m]), 0);
    endtask

    typedef struct {
        bit          w;
        bit          r;
        logic [15:0] d;
        int          c;
        bit          f;
        bit          af;
        bit          ae;
        bit          e;
    } vec_t;
    vec_t tv [9];

    initial begin
        tv[0] = '{1, 0, 16'hA0A0, 1, 1, 1, 0, 1};
        tv[1] = '{1, 0, 16'hB1B1, 2, 1, 1, 1, 1};
        tv[2] = '{1, 0, 16'hC2C2, 3, 1, 0, 1, 1};
        tv[3] = '{1, 0, 16'hD3D3, 4, 0, 0, 1, 1};
        tv[4] = '{1, 0, 16'hE4E4, 4, 0, 0, 1, 1};
        tv[5] = '{0, 1, 16'h0000, 3, 1, 0, 1, 1};
        tv[6] = '{0, 1, 16'h0000, 2, 1, 1, 1, 1};
        tv[7] = '{0, 1, 16'h0000, 1, 1, 1, 0, 1};
        tv[8] = '{0, 1, 16'h0000, 0, 1, 1, 0, 0};

        mc[0] = 0; mc[1] = 0;
        for (int k = 0; k < 2; k++) begin
            write[k] = 1'b0; write_ce[k] = 1'b0; read[k] = 1'b0; read_ce[k] = 1'b0; din[k] = '0;
        end
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int m = 0; m < 2; m++) begin
            chk("rst_count", cnt(m), 0);
            chk("rst_empty_n", int'(empty_n[m]), 0);
            chk("rst_full_n", int'(full_n[m]), 1);
            chk("rst_almost_full_n", int'(af_n[m]), 1);
            chk("rst_almost_empty_n", int'(ae_n[m]), 0);
        end

        // Shiftreg fill past full, then read back in order.
        for (int i = 0; i < 9; i++) begin
            cyc(0, tv[i].w, 1, tv[i].r, 1, tv[i].d);
            chk("tv_count", cnt(0), tv[i].c);
            chk("tv_full_n", int'(full_n[0]), int'(tv[i].f));
            chk("tv_almost_full_n", int'(af_n[0]), int'(tv[i].af));
            chk("tv_almost_empty_n", int'(ae_n[0]), int'(tv[i].ae));
            chk("tv_empty_n", int'(empty_n[0]), int'(tv[i].e));
        end

        // RAM latency, then random interleaving across several pointer wraps.
        cyc(1, 1, 1, 0, 0, 16'h1000);
        chk("ram_empty_n_after_1", int'(empty_n[1]), 0);
        chk("ram_count_in_flight", cnt(1), 1);
        cyc(1, 0, 0, 0, 0, 16'h0);
        chk("ram_empty_n_after_2", int'(empty_n[1]), 1);
        begin
            int nw = 1;
            for (int i = 0; i < 600 && nw < 21; i++) begin
                cyc(1, $urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0,
                    $urandom_range(0, 1) != 0, $urandom_range(0, 7) != 0, 16'h1000 + 16'(nw));
                if (last_wr) nw++;
            end
            if (nw < 21) fail("ram_random_write_timeout");
        end
        drain(1);

        for (int m = 0; m < 2; m++) begin
            // Streaming read+write at count=2.
            fill(m, 2, 16'h2000);
            cyc(m, 0, 0, 0, 0, 16'h0);
            for (int i = 0; i < 50; i++) begin
                cyc(m, 1, 1, 1, 1, 16'h2100 + 16'(i));
                chk("stream_count", cnt(m), 2);
                chk("stream_empty_n", int'(empty_n[m]), 1);
                chk("stream_almost_empty_n", int'(ae_n[m]), 1);
            end
            drain(m);

            // Read and write together while full: only the read lands.
            fill(m, depth(m), 16'h3000);
            cyc(m, 0, 0, 0, 0, 16'h0);
            cyc(m, 1, 1, 1, 1, 16'hDEAD);
            chk("full_rw_count", cnt(m), depth(m) - 1);
            chk("full_rw_full_n", int'(full_n[m]), 1);
            drain(m);

            // Qualifiers low: nothing moves.
            fill(m, 2, 16'h4000);
            cyc(m, 0, 0, 0, 0, 16'h0);
            repeat (10) cyc(m, 1, 0, 1, 0, 16'hBEEF);
            chk("ce_low_count", cnt(m), 2);
            drain(m);

            // Reset while writing at count=3.
            fill(m, 3, 16'h5000);
            cyc(m, 1, 1, 0, 0, 16'h7777, 1'b1);
            chk("midrst_count", cnt(m), 0);
            chk("midrst_empty_n", int'(empty_n[m]), 0);
            chk("midrst_full_n", int'(full_n[m]), 1);
            chk("midrst_almost_empty_n", int'(ae_n[m]), 0);
            chk("midrst_almost_full_n", int'(af_n[m]), 1);
            cyc(m, 1, 1, 0, 0, 16'h5A5A);
            chk("postrst_count", cnt(m), 1);
            if (m == 1) cyc(m, 0, 0, 0, 0, 16'h0);
            chk("postrst_empty_n", int'(empty_n[m]), 1);
            drain(m);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
